mac_controller: RTL and testbench
=================================

# mac_controller

Control FSM for the FinalMAC datapath. It sits directly upstream of the `counter` block: it drives the counter's `ld_N` and `dec_N` and reads the counter's `dout` back as `cnt` to decide when the vector loop ends. It also generates operand-memory read addresses and the load/enable strobes for the operand and accumulator registers. One `start` pulse runs one N-element multiply-accumulate, and `done` reports completion.

## Interface
- `CNT_W`, 16, width of the iteration count; equals the counter's `dout` width.
- `ADDR_W`, 8, width of the operand-memory address.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `start`  in  1  request one MAC run; sampled only in IDLE.
- `base`  in  ADDR_W  first operand address; captured in LOAD.
- `cnt`  in  CNT_W  remaining-iteration value from the counter (`dout`).
- `ld_N`  out  1  to counter: load N.
- `dec_N`  out  1  to counter: decrement by one.
- `clr_acc`  out  1  clear the accumulator register.
- `rd_en`  out  1  operand-memory read strobe; memory has a 1-cycle synchronous read.
- `addr`  out  ADDR_W  operand-memory address (registered).
- `ld_ab`  out  1  operand registers A/B capture the memory data.
- `en_acc`  out  1  accumulator adds the product A*B.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Moore FSM, one-hot or binary encoding (implementer's choice). States: IDLE, LOAD, CHECK, FETCH, LATCH, ACC, DONE.
- All strobes decode from the state register only. Each strobe is high only in the states listed below.
- IDLE: all strobes 0.
  - start=1 → LOAD.
- LOAD: `ld_N`=1, `clr_acc`=1; `addr` <= `base`.
  - → CHECK.
- CHECK: no strobes.
  - `cnt`==0 → DONE; otherwise → FETCH.
- FETCH: `rd_en`=1 at the current `addr`.
  - → LATCH.
- LATCH: `ld_ab`=1, capturing the data read in FETCH.
  - → ACC.
- ACC: `en_acc`=1, `dec_N`=1; `addr` <= `addr`+1.
  - → CHECK.
- DONE: `done`=1.
  - → IDLE.
- `addr` arithmetic is modulo 2^ADDR_W. The increment after address 2^ADDR_W−1 wraps to 0, and no flag is raised.
- `cnt` is only evaluated in CHECK.
  - The counter updates on the edge that leaves LOAD or ACC, so CHECK always sees the post-load or post-decrement value.
- No strobe is ever asserted in two consecutive states, except `busy`.

## Timing
- Reset (`clr`=1 at a rising edge) sets: state=IDLE, `addr`=0, and all outputs 0, including `busy` and `done`.
- `clr` overrides every other input, including `start` in the same cycle.
- Each element costs 4 cycles (CHECK, FETCH, LATCH, ACC).
- `done` goes high 4N+2 rising edges after the edge that sampled `start`=1 in IDLE, where N is the value loaded into the counter. It stays high exactly 1 cycle.
- `busy` is high from the edge after `start` is sampled through the DONE cycle inclusive.
  - Total `busy` duration is 4N+3 cycles.
- `start` while `busy`=1 is ignored and not queued.
- If `start` stays high through DONE, a new run begins: LOAD follows IDLE after exactly one IDLE cycle.
- `clr` mid-run aborts immediately. The next cycle is IDLE with all outputs 0 and no `done` pulse.
  - Counter and accumulator contents are not restored.
- N=0: the sequence is LOAD, CHECK, DONE, with no `rd_en`, `ld_ab` or `en_acc`.

## Test plan
- Reset: hold `clr`=1 with `start`=1 for 3 cycles → state IDLE, `addr`=0, all outputs 0 throughout.
- Basic run: N=7, `base`=0x10, pulse `start` → bench checks all of:
  - `ld_N` high once;
  - `addr` values 0x10..0x16 on the 7 `rd_en` pulses;
  - 7 `dec_N` pulses;
  - `done` exactly 30 edges after start;
  - the accumulator equals the reference dot product.
- Zero length: N=0 → `done` 2 edges after start; `rd_en`, `ld_ab` and `en_acc` never asserted; `busy` high for 3 cycles.
- Wrap and ignore:
  - N=3 with `base`=0xFE → addresses 0xFE, 0xFF, 0x00.
  - A second `start` pulse during the run → ignored; exactly one `done`.
- Abort: N=5, assert `clr` in the 3rd ACC cycle → next cycle IDLE, outputs 0, no `done`.
  - A fresh start with N=2 then completes in 10 edges.
- Back-to-back: hold `start`=1 continuously with N=1 → `done` pulses every 8 cycles (6 busy-to-done, DONE, 1 IDLE); `ld_N` precedes each run.

Source files
------------

// File: rtl/mac_controller.sv
// Control FSM for the FinalMAC datapath: sequences counter load/decrement,
// operand fetch, operand latch and accumulate for one N-element MAC per start.
module mac_controller #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  cnt,
  output logic              ld_N,
  output logic              dec_N,
  output logic              clr_acc,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              ld_ab,
  output logic              en_acc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_FETCH = 3'd3,
    S_LATCH = 3'd4,
    S_ACC   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        addr_d  = base;
        state_d = S_CHECK;
      end
      // cnt already reflects the load/decrement issued on the previous edge
      S_CHECK: state_d = (cnt == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_ACC;
      S_ACC: begin
        addr_d  = addr_q + 1'b1;
        state_d = S_CHECK;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign ld_N    = (state_q == S_LOAD);
  assign clr_acc = (state_q == S_LOAD);
  assign rd_en   = (state_q == S_FETCH);
  assign ld_ab   = (state_q == S_LATCH);
  assign en_acc  = (state_q == S_ACC);
  assign dec_N   = (state_q == S_ACC);
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign addr    = addr_q;

endmodule

// File: tb/tb_mac_controller.sv
// Bench for mac_controller: cycle table with a driven count, then runs against
// a behavioural counter, operand memory and accumulator.
module tb_mac_controller;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [7:0]  base;
  logic [15:0] cnt;
  logic        ld_N, dec_N, clr_acc, rd_en, ld_ab, en_acc, busy, done;
  logic [7:0]  addr;

  mac_controller #(.CNT_W(16), .ADDR_W(8)) dut (
    .clk(clk), .clr(clr), .start(start), .base(base), .cnt(cnt),
    .ld_N(ld_N), .dec_N(dec_N), .clr_acc(clr_acc), .rd_en(rd_en),
    .addr(addr), .ld_ab(ld_ab), .en_acc(en_acc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] outs;
  assign outs = {ld_N, dec_N, clr_acc, rd_en, ld_ab, en_acc, busy, done};

  // Environment: counter, 1-cycle memory, operand regs, accumulator
  logic        tbl_mode = 1'b1;
  logic [15:0] tbl_cnt, cnt_m, n_load;
  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  rd_a, rd_b, a_r, b_r;
  logic [31:0] acc;

  assign cnt = tbl_mode ? tbl_cnt : cnt_m;

  always @(posedge clk) begin
    if (ld_N) cnt_m <= n_load;
    else if (dec_N) cnt_m <= cnt_m - 16'd1;
    if (rd_en) begin
      rd_a <= mem_a[addr];
      rd_b <= mem_b[addr];
    end
    if (ld_ab) begin
      a_r <= rd_a;
      b_r <= rd_b;
    end
    if (clr_acc) acc <= '0;
    else if (en_acc) acc <= acc + 32'(a_r) * 32'(b_r);
  end

  int n_ld, n_rd, n_dec, n_lab, n_en, n_done, n_busy;
  logic [7:0] rd_addrs[$];

  always @(negedge clk) begin
    if (ld_N === 1'b1) n_ld++;
    if (rd_en === 1'b1) begin
      n_rd++;
      rd_addrs.push_back(addr);
    end
    if (dec_N === 1'b1) n_dec++;
    if (ld_ab === 1'b1) n_lab++;
    if (en_acc === 1'b1) n_en++;
    if (done === 1'b1) n_done++;
    if (busy === 1'b1) n_busy++;
  end

  task automatic clear_mon();
    n_ld = 0; n_rd = 0; n_dec = 0; n_lab = 0; n_en = 0; n_done = 0; n_busy = 0;
    rd_addrs.delete();
  endtask

  // Pulses start; returns edges from the sampling edge to done (400 = timeout)
  task automatic run(input int n, input logic [7:0] b, input int extra_at, output int edges);
    n_load = 16'(n);
    base   = b;
    clear_mon();
    start = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (done !== 1'b1 && edges < 400) begin
      start = (edges + 1 == extra_at);
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
  endtask

  function automatic logic [31:0] dot(input int n, input logic [7:0] b);
    logic [31:0] s = 0;
    logic [7:0]  idx = b;
    for (int i = 0; i < n; i++) begin
      s   = s + 32'(mem_a[idx]) * 32'(mem_b[idx]);
      idx = idx + 8'd1;
    end
    return s;
  endfunction

  typedef struct {
    logic        clr;
    logic        start;
    logic [7:0]  base;
    logic [15:0] cnt;
    logic [7:0]  eo;
    logic [7:0]  ea;
  } vec_t;

  vec_t tv[11];
  int   e;
  logic [7:0] ea;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'(i * 3 + 1);
      mem_b[i] = 8'(i) ^ 8'h5A;
    end
    // outs = {ld_N,dec_N,clr_acc,rd_en,ld_ab,en_acc,busy,done}, after the edge
    tv[0]  = '{1'b1, 1'b1, 8'hFF, 16'd0, 8'h00, 8'h00};
    tv[1]  = '{1'b1, 1'b1, 8'hFF, 16'd0, 8'h00, 8'h00};
    tv[2]  = '{1'b1, 1'b1, 8'hFF, 16'd0, 8'h00, 8'h00};
    tv[3]  = '{1'b0, 1'b1, 8'hFF, 16'd0, 8'hA2, 8'h00};
    tv[4]  = '{1'b0, 1'b0, 8'hFF, 16'd1, 8'h02, 8'hFF};
    tv[5]  = '{1'b0, 1'b0, 8'h00, 16'd1, 8'h12, 8'hFF};
    tv[6]  = '{1'b0, 1'b1, 8'h00, 16'd1, 8'h0A, 8'hFF};
    tv[7]  = '{1'b0, 1'b0, 8'h00, 16'd1, 8'h46, 8'hFF};
    tv[8]  = '{1'b0, 1'b0, 8'h00, 16'd0, 8'h02, 8'h00};
    tv[9]  = '{1'b0, 1'b0, 8'h00, 16'd0, 8'h03, 8'h00};
    tv[10] = '{1'b0, 1'b0, 8'h00, 16'd0, 8'h00, 8'h00};

    for (int i = 0; i < 11; i++) begin
      clr = tv[i].clr; start = tv[i].start; base = tv[i].base; tbl_cnt = tv[i].cnt;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_outs", i), 32'(outs), 32'(tv[i].eo));
      chk($sformatf("tbl%0d_addr", i), 32'(addr), 32'(tv[i].ea));
    end
    start = 1'b0;
    tbl_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic run N=7 at 0x10
    run(7, 8'h10, 0, e);
    chk("basic_done_edges", 32'(e), 32'd30);
    chk("basic_acc", acc, dot(7, 8'h10));
    repeat (3) @(posedge clk);
    #1;
    chk("basic_ld_n", 32'(n_ld), 32'd1);
    chk("basic_rd", 32'(n_rd), 32'd7);
    chk("basic_dec", 32'(n_dec), 32'd7);
    chk("basic_done_cnt", 32'(n_done), 32'd1);
    chk("basic_busy", 32'(n_busy), 32'd31);
    for (int i = 0; i < 7; i++)
      chk($sformatf("basic_addr%0d", i), (i < rd_addrs.size()) ? 32'(rd_addrs[i]) : 32'hDEAD,
          32'(8'h10 + 8'(i)));

    // Zero length
    run(0, 8'h40, 0, e);
    chk("zero_done_edges", 32'(e), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_rd", 32'(n_rd), 32'd0);
    chk("zero_ldab", 32'(n_lab), 32'd0);
    chk("zero_en", 32'(n_en), 32'd0);
    chk("zero_busy", 32'(n_busy), 32'd3);

    // Address wrap with an ignored second start
    run(3, 8'hFE, 5, e);
    chk("wrap_done_edges", 32'(e), 32'd14);
    chk("wrap_acc", acc, dot(3, 8'hFE));
    repeat (12) @(posedge clk);
    #1;
    chk("wrap_done_cnt", 32'(n_done), 32'd1);
    chk("wrap_ld_n", 32'(n_ld), 32'd1);
    chk("wrap_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ea = 8'hFE + 8'(i);
      chk($sformatf("wrap_addr%0d", i), (i < rd_addrs.size()) ? 32'(rd_addrs[i]) : 32'hDEAD, 32'(ea));
    end

    // Abort in the 3rd ACC cycle
    n_load = 16'd5; base = 8'h20;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int accs = 0;
      int g = 0;
      while (accs < 3 && g < 100) begin
        @(posedge clk); #1;
        g++;
        if (en_acc === 1'b1) accs++;
      end
      chk("abort_reached_acc3", 32'(accs), 32'd3);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("abort_outs", 32'(outs), 32'h0);
    chk("abort_addr", 32'(addr), 32'h0);
    clear_mon();
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(n_done), 32'd0);
    run(2, 8'h30, 0, e);
    chk("abort_restart_edges", 32'(e), 32'd10);
    chk("abort_restart_acc", acc, dot(2, 8'h30));
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back with start held high, N=1
    n_load = 16'd1; base = 8'h50;
    start = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_done_e%0d", k), 32'(done), 32'((k % 8) == 6));
      chk($sformatf("b2b_ldn_e%0d", k), 32'(ld_N), 32'((k % 8) == 0));
    end
    start = 1'b0;
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
